// File: rtl/bank_xbar_arb.sv
// Crossbar from one DMA port and NB per-bank PE ports to NB single-port SRAM banks,
// with DMA-priority arbitration, a starvation limit and pipelined read responses.
// Optional performance counters are enabled with `define BANK_XBAR_PERF_EN.
module bank_xbar_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NB         = 4,
  parameter int BSEL_W     = $clog2(NB),
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dma_req_valid,
  output logic                       dma_req_ready,
  input  logic                       dma_req_we,
  input  logic [BSEL_W-1:0]          dma_req_bank,
  input  logic [ADDR_W-1:0]          dma_req_addr,
  input  logic [DATA_W-1:0]          dma_req_wdata,
  output logic                       dma_rsp_valid,
  output logic [DATA_W-1:0]          dma_rsp_rdata,
  input  logic [NB-1:0]              pe_req_valid,
  output logic [NB-1:0]              pe_req_ready,
  input  logic [NB-1:0]              pe_req_we,
  input  logic [NB-1:0][ADDR_W-1:0]  pe_addr,
  input  logic [NB-1:0][DATA_W-1:0]  pe_wdata,
  output logic [NB-1:0]              pe_rsp_valid,
  output logic [NB-1:0][DATA_W-1:0]  pe_rsp_rdata,
  output logic [NB-1:0]              bank_en,
  output logic [NB-1:0]              bank_we,
  output logic [NB-1:0][ADDR_W-1:0]  bank_addr,
  output logic [NB-1:0][DATA_W-1:0]  bank_din,
  input  logic [NB-1:0][DATA_W-1:0]  bank_dout
`ifdef BANK_XBAR_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [31:0]                perf_conflict_cnt,
  output logic [31:0]                perf_force_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic                        dmaInRange;
  logic [NB-1:0]               dmaHit;
  logic [NB-1:0]               conflict;
  logic [NB-1:0]               forceGnt;
  logic [NB-1:0]               dmaGnt;
  logic [NB-1:0]               peGnt;
  logic [NB-1:0][CNT_W-1:0]    starveCnt_q, starveCnt_d;

  logic                        rdDma_d, rdOob_d;
  logic [BSEL_W-1:0]           rdBank_d;
  logic [NB-1:0]               rdPe_d;
  logic [RD_LAT-1:0]           rspDma_q, rspOob_q;
  logic [RD_LAT-1:0][BSEL_W-1:0] rspBank_q;
  logic [RD_LAT-1:0][NB-1:0]   rspPe_q;

  // A DMA bank select beyond NB is still accepted but never reaches a bank.
  always_comb begin
    dmaInRange = {1'b0, dma_req_bank} < (BSEL_W + 1)'(NB);
    for (int b = 0; b < NB; b++) begin
      dmaHit[b]      = dma_req_valid && dmaInRange && (dma_req_bank == BSEL_W'(b));
      conflict[b]    = dmaHit[b] && pe_req_valid[b];
      forceGnt[b]    = conflict[b] && (starveCnt_q[b] == CNT_W'(STARVE_MAX));
      dmaGnt[b]      = dmaHit[b] && !forceGnt[b];
      peGnt[b]       = pe_req_valid[b] && !dmaGnt[b];
      starveCnt_d[b] = (pe_req_valid[b] && dmaGnt[b]) ? starveCnt_q[b] + 1'b1 : '0;
    end
    dma_req_ready = dma_req_valid && !(|forceGnt);
    pe_req_ready  = peGnt;
  end

  always_comb begin
    bank_en   = '0;
    bank_we   = '0;
    bank_addr = '0;
    bank_din  = '0;
    for (int b = 0; b < NB; b++) begin
      if (dmaGnt[b]) begin
        bank_en[b]   = 1'b1;
        bank_we[b]   = dma_req_we;
        bank_addr[b] = dma_req_addr;
        bank_din[b]  = dma_req_wdata;
      end else if (peGnt[b]) begin
        bank_en[b]   = 1'b1;
        bank_we[b]   = pe_req_we[b];
        bank_addr[b] = pe_addr[b];
        bank_din[b]  = pe_wdata[b];
      end
    end
  end

  always_comb begin
    rdDma_d  = dma_req_valid && dma_req_ready && !dma_req_we;
    rdOob_d  = !dmaInRange;
    rdBank_d = dma_req_bank;
    rdPe_d   = peGnt & ~pe_req_we;
  end

  // Each stage tracks which requesters own the bank data arriving RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
      rspDma_q    <= '0;
      rspOob_q    <= '0;
      rspBank_q   <= '0;
      rspPe_q     <= '0;
    end else begin
      starveCnt_q  <= starveCnt_d;
      rspDma_q[0]  <= rdDma_d;
      rspOob_q[0]  <= rdOob_d;
      rspBank_q[0] <= rdBank_d;
      rspPe_q[0]   <= rdPe_d;
      for (int i = 1; i < RD_LAT; i++) begin
        rspDma_q[i]  <= rspDma_q[i-1];
        rspOob_q[i]  <= rspOob_q[i-1];
        rspBank_q[i] <= rspBank_q[i-1];
        rspPe_q[i]   <= rspPe_q[i-1];
      end
    end
  end

  always_comb begin
    dma_rsp_valid = rspDma_q[RD_LAT-1];
    dma_rsp_rdata = '0;
    if (dma_rsp_valid && !rspOob_q[RD_LAT-1]) begin
      for (int b = 0; b < NB; b++) begin
        if (rspBank_q[RD_LAT-1] == BSEL_W'(b)) dma_rsp_rdata = bank_dout[b];
      end
    end
    pe_rsp_valid = rspPe_q[RD_LAT-1];
    for (int b = 0; b < NB; b++) begin
      pe_rsp_rdata[b] = pe_rsp_valid[b] ? bank_dout[b] : '0;
    end
  end

`ifdef BANK_XBAR_PERF_EN
  logic [31:0] perfConflict_q, perfForce_q;

  // Saturating event counters; a clear request wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfConflict_q <= '0;
      perfForce_q    <= '0;
    end else if (perf_clr) begin
      perfConflict_q <= '0;
      perfForce_q    <= '0;
    end else begin
      if ((|conflict) && !(&perfConflict_q)) perfConflict_q <= perfConflict_q + 32'd1;
      if ((|forceGnt) && !(&perfForce_q))    perfForce_q    <= perfForce_q + 32'd1;
    end
  end

  assign perf_conflict_cnt = perfConflict_q;
  assign perf_force_cnt    = perfForce_q;
`endif

endmodule

// File: tb/tb_bank_xbar_arb.sv
// Directed bench for bank_xbar_arb: a 4-bank RD_LAT=2 instance with an SRAM model,
// plus a 3-bank RD_LAT=3 instance exercising out-of-range DMA bank selects.
module tb_bank_xbar_arb;

  logic clk = 1'b0;
  logic rstN;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  // Instance A: NB=4, RD_LAT=2, STARVE_MAX=4
  logic             aDmaValid, aDmaReady, aDmaWe;
  logic [1:0]       aDmaBank;
  logic [9:0]       aDmaAddr;
  logic [31:0]      aDmaWdata;
  logic             aRspValid;
  logic [31:0]      aRspData;
  logic [3:0]       aPeValid, aPeReady, aPeWe, aPeRspValid;
  logic [3:0][9:0]  aPeAddr;
  logic [3:0][31:0] aPeWdata, aPeRspData;
  logic [3:0]       aBankEn, aBankWe;
  logic [3:0][9:0]  aBankAddr;
  logic [3:0][31:0] aBankDin, aBankDout;

  // Instance B: NB=3, RD_LAT=3, STARVE_MAX=2
  logic             bDmaValid, bDmaReady, bDmaWe;
  logic [1:0]       bDmaBank;
  logic [9:0]       bDmaAddr;
  logic [31:0]      bDmaWdata;
  logic             bRspValid;
  logic [31:0]      bRspData;
  logic [2:0]       bPeValid, bPeReady, bPeWe, bPeRspValid;
  logic [2:0][9:0]  bPeAddr;
  logic [2:0][31:0] bPeWdata, bPeRspData;
  logic [2:0]       bBankEn, bBankWe;
  logic [2:0][9:0]  bBankAddr;
  logic [2:0][31:0] bBankDin, bBankDout;

`ifdef BANK_XBAR_PERF_EN
  logic        perfClr = 1'b0;
  logic [31:0] aPerfConflict, aPerfForce, bPerfConflict, bPerfForce;
`endif

  bank_xbar_arb #(.DATA_W(32), .ADDR_W(10), .NB(4), .RD_LAT(2), .STARVE_MAX(4)) uA (
    .clk(clk), .rst_n(rstN),
    .dma_req_valid(aDmaValid), .dma_req_ready(aDmaReady), .dma_req_we(aDmaWe),
    .dma_req_bank(aDmaBank), .dma_req_addr(aDmaAddr), .dma_req_wdata(aDmaWdata),
    .dma_rsp_valid(aRspValid), .dma_rsp_rdata(aRspData),
    .pe_req_valid(aPeValid), .pe_req_ready(aPeReady), .pe_req_we(aPeWe),
    .pe_addr(aPeAddr), .pe_wdata(aPeWdata),
    .pe_rsp_valid(aPeRspValid), .pe_rsp_rdata(aPeRspData),
    .bank_en(aBankEn), .bank_we(aBankWe), .bank_addr(aBankAddr),
    .bank_din(aBankDin), .bank_dout(aBankDout)
`ifdef BANK_XBAR_PERF_EN
    , .perf_clr(perfClr), .perf_conflict_cnt(aPerfConflict), .perf_force_cnt(aPerfForce)
`endif
  );

  bank_xbar_arb #(.DATA_W(32), .ADDR_W(10), .NB(3), .RD_LAT(3), .STARVE_MAX(2)) uB (
    .clk(clk), .rst_n(rstN),
    .dma_req_valid(bDmaValid), .dma_req_ready(bDmaReady), .dma_req_we(bDmaWe),
    .dma_req_bank(bDmaBank), .dma_req_addr(bDmaAddr), .dma_req_wdata(bDmaWdata),
    .dma_rsp_valid(bRspValid), .dma_rsp_rdata(bRspData),
    .pe_req_valid(bPeValid), .pe_req_ready(bPeReady), .pe_req_we(bPeWe),
    .pe_addr(bPeAddr), .pe_wdata(bPeWdata),
    .pe_rsp_valid(bPeRspValid), .pe_rsp_rdata(bPeRspData),
    .bank_en(bBankEn), .bank_we(bBankWe), .bank_addr(bBankAddr),
    .bank_din(bBankDin), .bank_dout(bBankDout)
`ifdef BANK_XBAR_PERF_EN
    , .perf_clr(perfClr), .perf_conflict_cnt(bPerfConflict), .perf_force_cnt(bPerfForce)
`endif
  );

  function automatic logic [31:0] pat(input int b, input int a);
    return 32'hA000_0000 | (32'(b) << 16) | 32'(a);
  endfunction

  // SRAM model for instance A with a two-stage read pipeline.
  logic [31:0]      memA [4][1024];
  logic             memReady = 1'b0;
  logic [3:0][31:0] rdStage0, rdStage1;

  always @(posedge clk) begin
    if (!memReady) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 1024; a++)
          memA[b][a] <= pat(b, a);
      memReady <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (aBankEn[b]) begin
          if (aBankWe[b]) memA[b][aBankAddr[b]] <= aBankDin[b];
          rdStage0[b] <= memA[b][aBankAddr[b]];
        end
      end
    end
    rdStage1 <= rdStage0;
  end

  assign aBankDout = rdStage1;
  assign bBankDout = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic dwe, input logic [1:0] db,
                               input logic [9:0] da, input logic [31:0] dw,
                               input logic [3:0] pv, input logic [3:0] pwe, input logic [9:0] pa);
    aDmaValid = dv;
    aDmaWe    = dwe;
    aDmaBank  = db;
    aDmaAddr  = da;
    aDmaWdata = dw;
    aPeValid  = pv;
    aPeWe     = pwe;
    for (int b = 0; b < 4; b++) begin
      aPeAddr[b]  = pa;
      aPeWdata[b] = '0;
    end
  endtask

  task automatic applyStimulusB(input logic dv, input logic dwe, input logic [1:0] db,
                                input logic [9:0] da);
    bDmaValid = dv;
    bDmaWe    = dwe;
    bDmaBank  = db;
    bDmaAddr  = da;
    bDmaWdata = 32'h1234_5678;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    applyStimulusB(0, 0, 0, 0);
    bPeValid = '0;
    bPeWe    = '0;
    bPeAddr  = '0;
    bPeWdata = '0;
    repeat (2) tick();
    #2;
    checkOutput("rst_dma_rsp_valid", aRspValid, 0);
    checkOutput("rst_dma_rsp_rdata", aRspData, 0);
    checkOutput("rst_pe_rsp_valid", aPeRspValid, 0);
    checkOutput("rst_pe_rsp_rdata", aPeRspData, 0);
    checkOutput("rst_bank_en", aBankEn, 0);
    checkOutput("rst_starve", uA.starveCnt_q, 0);
    checkOutput("rst_b_rsp_valid", bRspValid, 0);
    tick();
    rstN = 1'b1;

    // PE-only reads on every bank
    tick(); applyStimulus(0, 0, 0, 0, 0, 4'hF, 4'h0, 10'd5); #2;
    checkOutput("pe_rd_bank_en", aBankEn, 4'hF);
    checkOutput("pe_rd_ready", aPeReady, 4'hF);
    checkOutput("pe_rd_bank_we", aBankWe, 4'h0);
    checkOutput("pe_rd_addr2", aBankAddr[2], 10'd5);
    tick(); applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0); #2;
    checkOutput("pe_rsp_early", aPeRspValid, 4'h0);
    tick(); #2;
    checkOutput("pe_rsp_valid", aPeRspValid, 4'hF);
    checkOutput("pe_rsp_data0", aPeRspData[0], pat(0, 5));
    checkOutput("pe_rsp_data3", aPeRspData[3], pat(3, 5));
    tick(); #2;
    checkOutput("pe_rsp_single", aPeRspValid, 4'h0);
    checkOutput("pe_rsp_zero1", aPeRspData[1], 0);

    // DMA write contends with PE 2 read
    tick(); applyStimulus(1, 1, 2'd2, 10'h3F, 32'hDEAD_BEEF, 4'b0100, 4'h0, 10'd7); #2;
    checkOutput("cw_dma_ready", aDmaReady, 1);
    checkOutput("cw_pe_ready", aPeReady, 4'h0);
    checkOutput("cw_bank_en", aBankEn, 4'b0100);
    checkOutput("cw_bank_we", aBankWe, 4'b0100);
    checkOutput("cw_addr2", aBankAddr[2], 10'h3F);
    checkOutput("cw_din2", aBankDin[2], 32'hDEAD_BEEF);
    tick(); applyStimulus(0, 0, 0, 0, 0, 4'b0100, 4'h0, 10'd7); #2;
    checkOutput("cw_starve2", uA.starveCnt_q[2], 1);
    checkOutput("cw_pe_gnt", aPeReady, 4'b0100);
    checkOutput("cw_pe_we", aBankWe, 4'h0);
    checkOutput("cw_pe_addr2", aBankAddr[2], 10'd7);
    tick(); applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0); #2;
    checkOutput("cw_starve_clr", uA.starveCnt_q[2], 0);
    tick(); #2;
    checkOutput("cw_pe_rsp", aPeRspValid, 4'b0100);
    checkOutput("cw_pe_rdata", aPeRspData[2], pat(2, 7));

    // DMA read stream vs PE 1: forced grant every fifth cycle
    for (int i = 0; i < 10; i++) begin
      tick(); applyStimulus(1, 0, 2'd1, 10'd9, 0, 4'b0010, 4'h0, 10'd4); #2;
      checkOutput($sformatf("st_dma_ready_%0d", i), aDmaReady, (i % 5 == 4) ? 0 : 1);
      checkOutput($sformatf("st_pe_ready_%0d", i), aPeReady, (i % 5 == 4) ? 4'b0010 : 4'h0);
      checkOutput($sformatf("st_addr1_%0d", i), aBankAddr[1], (i % 5 == 4) ? 10'd4 : 10'd9);
    end
    repeat (3) begin
      tick(); applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    end

    // Back-to-back DMA reads to all banks
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 4) applyStimulus(1, 0, 2'(i), 10'h3F, 0, 4'h0, 4'h0, 0);
      else       applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
      #2;
      if (i < 4) checkOutput($sformatf("bb_ready_%0d", i), aDmaReady, 1);
      checkOutput($sformatf("bb_rsp_valid_%0d", i), aRspValid, (i >= 2 && i <= 5) ? 1 : 0);
      checkOutput($sformatf("bb_rsp_data_%0d", i), aRspData,
                  (i < 2 || i > 5) ? 32'h0 : ((i == 4) ? 32'hDEAD_BEEF : pat(i - 2, 10'h3F)));
    end

    // Reset while a DMA read is in flight
    tick(); applyStimulus(1, 0, 2'd0, 10'd1, 0, 4'h0, 4'h0, 0); #2;
    checkOutput("mr_accept", aDmaReady, 1);
    tick(); rstN = 1'b0; applyStimulus(0, 0, 0, 0, 0, 4'h0, 4'h0, 0); #2;
    checkOutput("mr_rsp_in_reset", aRspValid, 0);
    checkOutput("mr_starve", uA.starveCnt_q, 0);
    tick(); rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checkOutput($sformatf("mr_no_rsp_%0d", i), aRspValid, 0);
      tick();
    end

    // Out-of-range DMA bank on the 3-bank instance
    applyStimulusB(1, 0, 2'd3, 10'd2); #2;
    checkOutput("oob_rd_ready", bDmaReady, 1);
    checkOutput("oob_rd_bank_en", bBankEn, 3'b000);
    tick(); applyStimulusB(1, 0, 2'd2, 10'd5); #2;
    checkOutput("b_rd_ready", bDmaReady, 1);
    checkOutput("b_rd_bank_en", bBankEn, 3'b100);
    checkOutput("b_rsp_early1", bRspValid, 0);
    tick(); applyStimulusB(1, 1, 2'd3, 10'd6); #2;
    checkOutput("oob_wr_ready", bDmaReady, 1);
    checkOutput("oob_wr_bank_en", bBankEn, 3'b000);
    checkOutput("oob_wr_bank_we", bBankWe, 3'b000);
    checkOutput("b_rsp_early2", bRspValid, 0);
    tick(); applyStimulusB(0, 0, 0, 0); #2;
    checkOutput("oob_rsp_valid", bRspValid, 1);
    checkOutput("oob_rsp_data", bRspData, 0);
    tick(); #2;
    checkOutput("b_rsp_valid", bRspValid, 1);
    checkOutput("b_rsp_data", bRspData, 32'hC0DE_0002);
    tick(); #2;
    checkOutput("oob_wr_no_rsp", bRspValid, 0);
    checkOutput("oob_wr_no_data", bRspData, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
